// File: rtl/foc_seq_mc.sv
// foc_seq_mc: multi-channel FOC control-loop sequencer.
// The sequencer latches one sample set per accepted request, tagged with a
// channel. It then walks front (cordic+clarke) -> park -> PID -> inverse park
// -> inverse clarke -> SVM using one-cycle start pulses and done inputs.
// Each iteration ends with a one-cycle datapath reset (flush).
// Each wait state has a watchdog. On expiry the sequencer latches a fault and
// holds until fault_clr.
// Optional feature macro: FOC_SEQ_STATS_EN adds the iter_cycles/iter_count
// statistics outputs.
module foc_seq_mc #(
  parameter int D_WIDTH = 19,
  parameter int N_CH    = 2,
  parameter int PID_LAT = 1,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  localparam int CH_W   = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               valid,
  output logic               ready,
  input  logic [CH_W-1:0]    ch_in,
  input  logic [D_WIDTH-1:0] angle_in,
  input  logic [D_WIDTH-1:0] currA_in,
  input  logic [D_WIDTH-1:0] currB_in,
  input  logic [D_WIDTH-1:0] currC_in,
  input  logic [D_WIDTH-1:0] currT_in,
  input  logic [15:0]        period_in,
  output logic [D_WIDTH-1:0] angle_r,
  output logic [D_WIDTH-1:0] currA_r,
  output logic [D_WIDTH-1:0] currB_r,
  output logic [D_WIDTH-1:0] currC_r,
  output logic [D_WIDTH-1:0] currT_r,
  output logic [15:0]        period_r,
  output logic [CH_W-1:0]    ch_sel,
  output logic               start_front,
  output logic               start_park,
  output logic               start_pid,
  output logic               start_ipark,
  output logic               start_iclarke,
  output logic               start_svm,
  input  logic               done_cordic,
  input  logic               done_clarke,
  input  logic               done_park,
  input  logic               done_ipark,
  input  logic               done_iclarke,
  input  logic               done_svm,
  output logic               mod_rstb,
  output logic               fault,
  output logic [2:0]         fault_stage,
  input  logic               fault_clr
`ifdef FOC_SEQ_STATS_EN
  ,
  output logic [15:0]        iter_cycles,
  output logic [15:0]        iter_count
`endif
);

  localparam int PL_W = (PID_LAT > 2) ? $clog2(PID_LAT) : 1;
  localparam logic [PL_W-1:0] PID_LAST = PL_W'(PID_LAT - 1);
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] WD_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CH_W-1:0] CH_MAX = CH_W'(N_CH - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FRONT, S_PARK, S_PID, S_IPARK, S_ICLARKE, S_SVM, S_FLUSH, S_FAULT
  } state_t;

  state_t          state;
  logic [TO_W-1:0] wd_cnt;
  logic [PL_W-1:0] pid_cnt;
  logic            seen_cordic;
  logic            seen_clarke;
  logic            in_wait;
  logic            stage_done;
  logic [2:0]      stage_code;
  logic            wd_expire;

  // Out-of-range channel requests fold onto the highest channel.
  function automatic logic [CH_W-1:0] clamp_ch(input logic [CH_W-1:0] c);
    logic [CH_W-1:0] r;
    r = c;
    if (int'(c) >= N_CH) r = CH_MAX;
    return r;
  endfunction

  // Decode which wait state is active, its completion condition and fault code.
  always_comb begin
    in_wait    = 1'b0;
    stage_done = 1'b0;
    stage_code = 3'd0;
    case (state)
      S_FRONT: begin
        in_wait    = 1'b1;
        stage_done = (seen_cordic | done_cordic) & (seen_clarke | done_clarke);
        stage_code = 3'd1;
      end
      S_PARK:    begin in_wait = 1'b1; stage_done = done_park;    stage_code = 3'd2; end
      S_IPARK:   begin in_wait = 1'b1; stage_done = done_ipark;   stage_code = 3'd3; end
      S_ICLARKE: begin in_wait = 1'b1; stage_done = done_iclarke; stage_code = 3'd4; end
      S_SVM:     begin in_wait = 1'b1; stage_done = done_svm;     stage_code = 3'd5; end
      default:   begin in_wait = 1'b0; stage_done = 1'b0;         stage_code = 3'd0; end
    endcase
  end

  assign wd_expire = WD_EN && (wd_cnt == WD_LAST);

  // Sequencer FSM with registered starts, handshake, sample latch and watchdog.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state         <= S_IDLE;
      ready         <= 1'b1;
      mod_rstb      <= 1'b0;
      fault         <= 1'b0;
      fault_stage   <= 3'd0;
      start_front   <= 1'b0;
      start_park    <= 1'b0;
      start_pid     <= 1'b0;
      start_ipark   <= 1'b0;
      start_iclarke <= 1'b0;
      start_svm     <= 1'b0;
      wd_cnt        <= '0;
      pid_cnt       <= '0;
      seen_cordic   <= 1'b0;
      seen_clarke   <= 1'b0;
      angle_r       <= '0;
      currA_r       <= '0;
      currB_r       <= '0;
      currC_r       <= '0;
      currT_r       <= '0;
      period_r      <= '0;
      ch_sel        <= '0;
    end else begin
      start_front   <= 1'b0;
      start_park    <= 1'b0;
      start_pid     <= 1'b0;
      start_ipark   <= 1'b0;
      start_iclarke <= 1'b0;
      start_svm     <= 1'b0;
      mod_rstb      <= 1'b1;
      if (in_wait && stage_done) begin
        // A done on the watchdog-limit edge still advances (done wins).
        wd_cnt <= '0;
        case (state)
          S_FRONT: begin
            start_park  <= 1'b1;
            seen_cordic <= 1'b0;
            seen_clarke <= 1'b0;
            state       <= S_PARK;
          end
          S_PARK: begin
            start_pid <= 1'b1;
            pid_cnt   <= '0;
            state     <= S_PID;
          end
          S_IPARK: begin
            start_iclarke <= 1'b1;
            state         <= S_ICLARKE;
          end
          S_ICLARKE: begin
            start_svm <= 1'b1;
            state     <= S_SVM;
          end
          default: begin
            mod_rstb <= 1'b0;
            state    <= S_FLUSH;
          end
        endcase
      end else if (in_wait) begin
        if (state == S_FRONT) begin
          seen_cordic <= seen_cordic | done_cordic;
          seen_clarke <= seen_clarke | done_clarke;
        end
        if (wd_expire) begin
          state       <= S_FAULT;
          fault       <= 1'b1;
          fault_stage <= stage_code;
          mod_rstb    <= 1'b0;
          seen_cordic <= 1'b0;
          seen_clarke <= 1'b0;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            ready <= 1'b1;
            if (valid && ready) begin
              angle_r     <= angle_in;
              currA_r     <= currA_in;
              currB_r     <= currB_in;
              currC_r     <= currC_in;
              currT_r     <= currT_in;
              period_r    <= period_in;
              ch_sel      <= clamp_ch(ch_in);
              ready       <= 1'b0;
              start_front <= 1'b1;
              wd_cnt      <= '0;
              seen_cordic <= 1'b0;
              seen_clarke <= 1'b0;
              state       <= S_FRONT;
            end
          end
          S_PID: begin
            if (pid_cnt == PID_LAST) begin
              start_ipark <= 1'b1;
              wd_cnt      <= '0;
              state       <= S_IPARK;
            end else begin
              pid_cnt <= pid_cnt + 1'b1;
            end
          end
          S_FLUSH: begin
            ready <= 1'b1;
            state <= S_IDLE;
          end
          S_FAULT: begin
            if (fault_clr) begin
              fault       <= 1'b0;
              fault_stage <= 3'd0;
              ready       <= 1'b1;
              state       <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef FOC_SEQ_STATS_EN
  logic [15:0] cyc_cnt;

  // Iteration length (accept edge to ready rise) and completed-iteration count.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      cyc_cnt     <= '0;
      iter_cycles <= '0;
      iter_count  <= '0;
    end else begin
      if (state == S_IDLE && valid && ready)
        cyc_cnt <= 16'd1;
      else if (state != S_IDLE && state != S_FAULT && cyc_cnt != 16'hFFFF)
        cyc_cnt <= cyc_cnt + 16'd1;
      if (state == S_FLUSH) begin
        iter_cycles <= cyc_cnt;
        iter_count  <= iter_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_foc_seq_mc.sv
// tb_foc_seq_mc: self-checking bench for foc_seq_mc with a done-responder
// and a schedule model derived from per-stage response delays.
module tb_foc_seq_mc;
  localparam int D   = 19;
  localparam int NCH = 3;
  localparam int PL  = 1;
  localparam int TO  = 16;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rstb = 1'b0;
  logic           valid = 1'b0;
  logic           fault_clr = 1'b0;
  logic [CHW-1:0] ch_in = '0;
  logic [D-1:0]   angle_in = '0, currA_in = '0, currB_in = '0, currC_in = '0, currT_in = '0;
  logic [15:0]    period_in = '0;
  logic           ready, mod_rstb, fault;
  logic [2:0]     fault_stage;
  logic [D-1:0]   angle_r, currA_r, currB_r, currC_r, currT_r;
  logic [15:0]    period_r;
  logic [CHW-1:0] ch_sel;
  logic           start_front, start_park, start_pid, start_ipark, start_iclarke, start_svm;
  logic [5:0]     dn = '0;
`ifdef FOC_SEQ_STATS_EN
  logic [15:0]    iter_cycles, iter_count;
`endif

  // Responder delays per done (cordic, clarke, park, ipark, iclarke, svm); 0 = never.
  int dly[6];
  int cnt[6];
  int obs_first[6];
  int obs_np[6];
  int obs_edges, obs_mlow;
  int exp_sched[7];
  int total = 0, passed = 0;
  int exp_count = 0, exp_cycles = 0;

  foc_seq_mc #(.D_WIDTH(D), .N_CH(NCH), .PID_LAT(PL), .TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rstb(rstb), .valid(valid), .ready(ready), .ch_in(ch_in),
    .angle_in(angle_in), .currA_in(currA_in), .currB_in(currB_in),
    .currC_in(currC_in), .currT_in(currT_in), .period_in(period_in),
    .angle_r(angle_r), .currA_r(currA_r), .currB_r(currB_r), .currC_r(currC_r),
    .currT_r(currT_r), .period_r(period_r), .ch_sel(ch_sel),
    .start_front(start_front), .start_park(start_park), .start_pid(start_pid),
    .start_ipark(start_ipark), .start_iclarke(start_iclarke), .start_svm(start_svm),
    .done_cordic(dn[0]), .done_clarke(dn[1]), .done_park(dn[2]),
    .done_ipark(dn[3]), .done_iclarke(dn[4]), .done_svm(dn[5]),
    .mod_rstb(mod_rstb), .fault(fault), .fault_stage(fault_stage), .fault_clr(fault_clr)
`ifdef FOC_SEQ_STATS_EN
    , .iter_cycles(iter_cycles), .iter_count(iter_count)
`endif
  );

  always #5 clk = ~clk;

  // Datapath stand-in: each done pulses dly[k] cycles after its start pulse.
  always @(posedge clk) begin : responder
    logic [5:0] st;
    #1;
    st = {start_svm, start_iclarke, start_ipark, start_park, start_front, start_front};
    if (!rstb) begin
      for (int k = 0; k < 6; k++) cnt[k] = 0;
      dn = '0;
    end else begin
      for (int k = 0; k < 6; k++) begin
        dn[k] = 1'b0;
        if (cnt[k] > 0) begin
          cnt[k] = cnt[k] - 1;
          if (cnt[k] == 0) dn[k] = 1'b1;
        end
        if (st[k] && dly[k] > 0) cnt[k] = dly[k];
      end
    end
  end

  // Expected start indices (edges after accept) and ready-rise edge.
  task automatic model_sched();
    int m;
    m = (dly[0] > dly[1]) ? dly[0] : dly[1];
    exp_sched[0] = 0;
    exp_sched[1] = m + 1;
    exp_sched[2] = exp_sched[1] + dly[2] + 1;
    exp_sched[3] = exp_sched[2] + PL;
    exp_sched[4] = exp_sched[3] + dly[3] + 1;
    exp_sched[5] = exp_sched[4] + dly[4] + 1;
    exp_sched[6] = exp_sched[5] + dly[5] + 2;
  endtask

  task automatic set_req(input int ch);
    ch_in     = CHW'(ch);
    angle_in  = D'($urandom);
    currA_in  = D'($urandom);
    currB_in  = D'($urandom);
    currC_in  = D'($urandom);
    currT_in  = D'($urandom);
    period_in = 16'($urandom);
  endtask

  // Issue one request and observe start pulses until ready rises.
  task automatic run_iter();
    logic [5:0] sv;
    int j;
    for (int k = 0; k < 6; k++) begin obs_first[k] = -1; obs_np[k] = 0; end
    obs_mlow = 0;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    j = 0;
    forever begin
      sv = {start_svm, start_iclarke, start_ipark, start_pid, start_park, start_front};
      for (int k = 0; k < 6; k++)
        if (sv[k]) begin
          obs_np[k]++;
          if (obs_first[k] < 0) obs_first[k] = j;
        end
      if (!mod_rstb) obs_mlow++;
      if (ready === 1'b1 || j >= 400) break;
      @(posedge clk); #1;
      j++;
    end
    obs_edges = j;
  endtask

  task automatic test_reset();
    rstb = 1'b0; valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else passed++;
    total++; if (mod_rstb !== 1'b0) $display("FAIL reset_mod_rstb: got %b want 0", mod_rstb); else passed++;
    total++; if ({fault, fault_stage} !== 4'd0) $display("FAIL reset_fault: got %b/%0d want 0/0", fault, fault_stage); else passed++;
    total++;
    if ({start_front, start_park, start_pid, start_ipark, start_iclarke, start_svm} !== 6'd0)
      $display("FAIL reset_starts: got nonzero want 000000");
    else passed++;
    total++;
    if (angle_r !== '0 || currT_r !== '0 || period_r !== '0 || ch_sel !== '0)
      $display("FAIL reset_samples: got angle %h ch %0d want 0", angle_r, ch_sel);
    else passed++;
`ifdef FOC_SEQ_STATS_EN
    total++; if (iter_count !== 16'd0 || iter_cycles !== 16'd0) $display("FAIL reset_stats: got %0d/%0d want 0/0", iter_count, iter_cycles); else passed++;
`endif
    rstb = 1'b1;
    @(posedge clk); #1;
    total++; if (mod_rstb !== 1'b1 || ready !== 1'b1) $display("FAIL reset_release: got mod_rstb %b ready %b want 1 1", mod_rstb, ready); else passed++;
  endtask

  task automatic test_single();
    dly = '{1, 1, 1, 1, 1, 1};
    set_req(1);
    angle_in = 19'h12345;
    model_sched();
    run_iter();
    total++; if (obs_edges !== 12 || exp_sched[6] !== 12) $display("FAIL single_latency: got %0d want 12", obs_edges); else passed++;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (obs_first[k] !== exp_sched[k] || obs_np[k] !== 1)
        $display("FAIL single_start%0d: got edge %0d count %0d want edge %0d count 1", k, obs_first[k], obs_np[k], exp_sched[k]);
      else passed++;
    end
    total++; if (obs_mlow !== 1) $display("FAIL single_flush: got %0d low cycles want 1", obs_mlow); else passed++;
    total++; if (ch_sel !== 2'd1) $display("FAIL single_ch_sel: got %0d want 1", ch_sel); else passed++;
    total++; if (angle_r !== 19'h12345) $display("FAIL single_angle: got %h want 12345", angle_r); else passed++;
    total++;
    if (currA_r !== currA_in || currB_r !== currB_in || currC_r !== currC_in || currT_r !== currT_in || period_r !== period_in)
      $display("FAIL single_samples: got %h %h want %h %h", currA_r, period_r, currA_in, period_in);
    else passed++;
    exp_count++; exp_cycles = exp_sched[6];
`ifdef FOC_SEQ_STATS_EN
    total++; if (iter_cycles !== 16'(exp_cycles) || iter_count !== 16'(exp_count)) $display("FAIL single_stats: got %0d/%0d want %0d/%0d", iter_cycles, iter_count, exp_cycles, exp_count); else passed++;
`endif
  endtask

  task automatic test_sticky();
    for (int v = 0; v < 2; v++) begin
      if (v == 0) dly = '{4, 1, 1, 1, 1, 1};
      else        dly = '{2, 6, 1, 1, 1, 1};
      set_req(2);
      model_sched();
      run_iter();
      total++;
      if (obs_first[1] !== exp_sched[1] || obs_np[1] !== 1)
        $display("FAIL sticky%0d_park: got edge %0d count %0d want edge %0d count 1", v, obs_first[1], obs_np[1], exp_sched[1]);
      else passed++;
      total++; if (obs_edges !== exp_sched[6]) $display("FAIL sticky%0d_latency: got %0d want %0d", v, obs_edges, exp_sched[6]); else passed++;
      exp_count++; exp_cycles = exp_sched[6];
    end
  endtask

  task automatic test_random();
    int ch, e;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 6; k++) dly[k] = $urandom_range(1, 10);
      ch = $urandom_range(0, 3);
      set_req(ch);
      model_sched();
      run_iter();
      e = (ch >= NCH) ? NCH - 1 : ch;
      total++; if (obs_edges !== exp_sched[6]) $display("FAIL rand%0d_latency: got %0d want %0d", it, obs_edges, exp_sched[6]); else passed++;
      total++;
      if (obs_first[1] !== exp_sched[1] || obs_first[3] !== exp_sched[3] || obs_first[5] !== exp_sched[5])
        $display("FAIL rand%0d_starts: got %0d %0d %0d want %0d %0d %0d", it, obs_first[1], obs_first[3], obs_first[5], exp_sched[1], exp_sched[3], exp_sched[5]);
      else passed++;
      total++; if (ch_sel !== CHW'(e) || angle_r !== angle_in) $display("FAIL rand%0d_latch: got ch %0d angle %h want ch %0d angle %h", it, ch_sel, angle_r, e, angle_in); else passed++;
      exp_count++; exp_cycles = exp_sched[6];
`ifdef FOC_SEQ_STATS_EN
      total++; if (iter_cycles !== 16'(exp_cycles) || iter_count !== 16'(exp_count)) $display("FAIL rand%0d_stats: got %0d/%0d want %0d/%0d", it, iter_cycles, iter_count, exp_cycles, exp_count); else passed++;
`endif
    end
  endtask

  task automatic test_done_wins();
    for (int v = 0; v < 2; v++) begin
      if (v == 0) dly = '{1, 1, 1, 1, 1, TO - 1};
      else        dly = '{TO - 1, 2, TO - 1, TO - 1, TO - 1, TO - 1};
      set_req(0);
      model_sched();
      run_iter();
      total++; if (fault !== 1'b0 || fault_stage !== 3'd0) $display("FAIL donewins%0d_fault: got %b/%0d want 0/0", v, fault, fault_stage); else passed++;
      total++; if (obs_edges !== exp_sched[6] || obs_mlow !== 1) $display("FAIL donewins%0d_latency: got %0d flush %0d want %0d flush 1", v, obs_edges, obs_mlow, exp_sched[6]); else passed++;
      exp_count++; exp_cycles = exp_sched[6];
    end
  endtask

  task automatic test_fault();
    int j, bad;
    logic [D-1:0] saved;
    dly = '{1, 1, 0, 1, 1, 1};
    set_req(2);
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    j = 0; bad = 0;
    while (fault !== 1'b1 && j < 100) begin
      if (ready !== 1'b0) bad++;
      @(posedge clk); #1;
      j++;
    end
    total++; if (j !== 2 + TO) $display("FAIL fault_time: got %0d edges want %0d", j, 2 + TO); else passed++;
    total++; if (fault_stage !== 3'd2) $display("FAIL fault_stage: got %0d want 2", fault_stage); else passed++;
    total++; if (mod_rstb !== 1'b0 || ready !== 1'b0 || bad !== 0) $display("FAIL fault_entry: got mod_rstb %b ready %b bad %0d want 0 0 0", mod_rstb, ready, bad); else passed++;
    total++;
    if ({start_front, start_park, start_pid, start_ipark, start_iclarke, start_svm} !== 6'd0)
      $display("FAIL fault_starts: got nonzero want 000000");
    else passed++;
    saved = angle_r;
    set_req(1);
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (ready !== 1'b0 || start_front !== 1'b0 || fault !== 1'b1 || mod_rstb !== 1'b1 || angle_r !== saved)
        $display("FAIL fault_hold%0d: got ready %b start %b fault %b mod_rstb %b angle %h want 0 0 1 1 %h", i, ready, start_front, fault, mod_rstb, angle_r, saved);
      else passed++;
    end
    valid = 1'b0;
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    total++; if (ready !== 1'b1 || fault !== 1'b0 || fault_stage !== 3'd0) $display("FAIL fault_clear: got ready %b fault %b stage %0d want 1 0 0", ready, fault, fault_stage); else passed++;
`ifdef FOC_SEQ_STATS_EN
    total++; if (iter_count !== 16'(exp_count) || iter_cycles !== 16'(exp_cycles)) $display("FAIL fault_stats: got %0d/%0d want %0d/%0d", iter_count, iter_cycles, exp_count, exp_cycles); else passed++;
`endif
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    total++; if (ready !== 1'b1 || fault !== 1'b0 || start_front !== 1'b0) $display("FAIL idle_clr: got ready %b fault %b start %b want 1 0 0", ready, fault, start_front); else passed++;
  endtask

  task automatic test_reset_mid();
    int j;
    dly = '{1, 1, 1, 5, 1, 1};
    set_req(1);
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    j = 0;
    while (start_ipark !== 1'b1 && j < 50) begin @(posedge clk); #1; j++; end
    total++; if (j !== 5) $display("FAIL midrst_ipark: got edge %0d want 5", j); else passed++;
    @(posedge clk); #1;
    rstb = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({start_front, start_park, start_pid, start_ipark, start_iclarke, start_svm} !== 6'd0 || ready !== 1'b1 || mod_rstb !== 1'b0)
      $display("FAIL midrst_ctrl: got ready %b mod_rstb %b want 1 0", ready, mod_rstb);
    else passed++;
    total++; if (angle_r !== '0 || ch_sel !== '0 || period_r !== '0) $display("FAIL midrst_samples: got angle %h ch %0d want 0 0", angle_r, ch_sel); else passed++;
    exp_count = 0; exp_cycles = 0;
`ifdef FOC_SEQ_STATS_EN
    total++; if (iter_count !== 16'd0 || iter_cycles !== 16'd0) $display("FAIL midrst_stats: got %0d/%0d want 0/0", iter_count, iter_cycles); else passed++;
`endif
    @(posedge clk); #1;
    rstb = 1'b1;
    @(posedge clk); #1;
    dly = '{1, 1, 1, 1, 1, 1};
    set_req(0);
    model_sched();
    run_iter();
    total++; if (obs_edges !== exp_sched[6] || ch_sel !== 2'd0 || angle_r !== angle_in) $display("FAIL midrst_after: got %0d edges ch %0d want %0d ch 0", obs_edges, ch_sel, exp_sched[6]); else passed++;
    exp_count++; exp_cycles = exp_sched[6];
  endtask

  task automatic test_back_to_back();
    int seq[3];
    int j;
    seq = '{0, 1, 0};
    dly = '{1, 1, 1, 1, 1, 1};
    model_sched();
    set_req(seq[0]);
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (ready !== 1'b0 || ch_sel !== CHW'(seq[i]) || angle_r !== angle_in)
        $display("FAIL b2b%0d_accept: got ready %b ch %0d angle %h want 0 %0d %h", i, ready, ch_sel, angle_r, seq[i], angle_in);
      else passed++;
      if (i < 2) set_req(seq[i + 1]);
      else valid = 1'b0;
      j = 0;
      while (ready !== 1'b1 && j < 100) begin @(posedge clk); #1; j++; end
      total++; if (j !== exp_sched[6]) $display("FAIL b2b%0d_latency: got %0d want %0d", i, j, exp_sched[6]); else passed++;
      exp_count++; exp_cycles = exp_sched[6];
    end
`ifdef FOC_SEQ_STATS_EN
    total++; if (iter_count !== 16'(exp_count) || iter_cycles !== 16'(exp_cycles)) $display("FAIL b2b_stats: got %0d/%0d want %0d/%0d", iter_count, iter_cycles, exp_count, exp_cycles); else passed++;
`endif
  endtask

  initial begin
    dly = '{1, 1, 1, 1, 1, 1};
    test_reset();
    test_single();
    test_sticky();
    test_random();
    test_done_wins();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/foc_seq_mc.md
# foc_seq_mc

Multi-channel FOC control-loop sequencer; parametrised successor of the single-channel top-level sequencer. It latches one sample set per request, tagged with a channel ID, and walks the cordic/clarke → park → PID → inverse park → inverse clarke → SVM chain with one-cycle start pulses and done handshakes. It adds sticky front-stage done capture, configurable PID settle time, a per-stage watchdog with fault latch, and a flush reset pulse after every iteration. Instantiated in the top level in place of the inline state machine; datapath blocks are unchanged.

## Interface
- D_WIDTH, 19, sample word width (angle, currents, target).
- N_CH, 2, motor channels time-multiplexed over one datapath; CH_W = max(1, $clog2(N_CH)).
- PID_LAT, 1, cycles spent in the PID state before the inverse park starts (≥1).
- TIMEOUT, 255, watchdog limit in cycles per wait state; 0 disables the watchdog.
- TO_W, 8, watchdog counter width; TIMEOUT < 2^TO_W.

- clk  in  1  clock, all logic on rising edge.
- rstb  in  1  synchronous active-low reset.
- valid  in  1  request; accepted on an edge where valid && ready.
- ready  out  1  high only in IDLE; reset value 1.
- ch_in  in  CH_W  channel of request; values ≥ N_CH are accepted as N_CH-1.
- angle_in, currA_in, currB_in, currC_in, currT_in  in  D_WIDTH each  sample set.
- period_in  in  16  SVM period top.
- angle_r, currA_r, currB_r, currC_r, currT_r  out  D_WIDTH  latched samples; reset 0.
- period_r  out  16  latched period; reset 0.
- ch_sel  out  CH_W  latched channel; drives PID bank/SVM output muxes; reset 0.
- start_front, start_park, start_pid, start_ipark, start_iclarke, start_svm  out  1 each  one-cycle start pulses; reset 0.
- done_cordic, done_clarke, done_park, done_ipark, done_iclarke, done_svm  in  1 each  stage completion.
- mod_rstb  out  1  datapath module reset, active-low; reset value 0.
- fault  out  1  watchdog fault latched; reset 0.
- fault_stage  out  3  1 FRONT, 2 PARK, 3 IPARK, 4 ICLARKE, 5 SVM, 0 none; reset 0.
- fault_clr  in  1  clears fault, returns to IDLE.

## Operation
- States: IDLE, FRONT, PARK, PID, IPARK, ICLARKE, SVM, FLUSH, FAULT.
- IDLE: ready=1, mod_rstb=1. On accept: latch all samples and ch_sel, ready←0, start_front←1, →FRONT.
- FRONT: cordic and clarke done bits captured sticky (either order, any cycle); when both set (including the current cycle's inputs) → start_park←1, →PARK; sticky bits cleared.
- PARK / IPARK / ICLARKE / SVM: on stage done → assert next start (start_pid, start_ipark via PID, start_iclarke, none after SVM), advance. SVM done → FLUSH.
- PID: fixed PID_LAT cycles, no done input, no watchdog; then start_ipark←1, →IPARK.
- FLUSH: mod_rstb←0 for exactly one cycle; →IDLE with ready←1, mod_rstb←1.
- Watchdog: counter cleared on entry to each wait state, increments each cycle without done; reaching TIMEOUT → FAULT, fault←1, fault_stage←code, mod_rstb←0 for one cycle, all starts 0.
- FAULT: ready=0, valid ignored; fault_clr → IDLE, fault←0, fault_stage←0. Done inputs ignored.
- Done inputs outside their wait state are ignored (except FRONT sticky capture).
- Latched samples hold until next accept; unaffected by FLUSH/FAULT.

## Timing
- Start pulses registered: asserted the cycle after the transition-causing edge, high one cycle.
- Done sampled on the edge; stage done high on edge k → next start high after edge k.
- With every done returned one cycle after its start and PID_LAT=1: ready rises 12 edges after accept edge; generally 11+PID_LAT plus added stage waits.
- Done and watchdog limit on the same edge: done wins.
- fault_clr while not in FAULT: no effect.
- rstb low on any edge, mid-operation included: all outputs to reset values next edge, state IDLE; mod_rstb rises one edge after rstb release.

## Configuration
- FOC_SEQ_STATS_EN defined: adds outputs iter_cycles[15:0] (edges from accept to ready rise of last completed iteration, saturating at 0xFFFF) and iter_count[15:0] (completed iterations, wrapping); both reset 0, unchanged on FAULT.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset, then single request ch_in=1, angle 0x12345, all dones 1 cycle after start, PID_LAT=1 -> ch_sel=1, angle_r=0x12345, starts in order, mod_rstb low one cycle, ready high 12 edges after accept; iter_cycles=12, iter_count=1.
- done_clarke 3 cycles before done_cordic -> start_park exactly one cycle after done_cordic edge; no second start_park.
- TIMEOUT=16, done_park withheld -> fault=1, fault_stage=2 after 16 cycles in PARK, mod_rstb low one cycle, ready=0; valid ignored; fault_clr -> IDLE, ready=1, fault_stage=0.
- done_svm on the same edge the counter reaches TIMEOUT -> no fault, FLUSH then IDLE.
- rstb low mid-IPARK -> all starts 0, ready=1, mod_rstb=0, samples 0; next request completes normally.
- Back-to-back requests ch 0, 1, 0 with valid held high -> three iterations, ch_sel per request, ready low throughout each, iter_count=3.
